// File: rtl/ftc_pkg.sv
// Shared types and helpers for the five-to-three counter vector runner.
// A vector packs the stimulus {cin,i1,i2,i3,i4} above the expected result {c,cout,s}.
package ftc_pkg;

    localparam int FTC_IN_W  = 5;
    localparam int FTC_OUT_W = 3;
    localparam int FTC_VEC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ftc_run_state_e;

    function automatic logic [FTC_IN_W-1:0] vec_stim(input logic [FTC_VEC_W-1:0] v);
        return v[FTC_VEC_W-1 -: FTC_IN_W];
    endfunction

    function automatic logic [FTC_OUT_W-1:0] vec_exp(input logic [FTC_VEC_W-1:0] v);
        return v[FTC_OUT_W-1:0];
    endfunction

endpackage

// File: rtl/ftc_vec_mem.sv
// Vector store: DEPTH x 8 register array, synchronous write, asynchronous read.
// Reads beyond DEPTH return zero so the caller may look one slot past the end.
module ftc_vec_mem
    import ftc_pkg::*;
#(
    parameter int DEPTH = 9,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 i_we,
    input  logic [AW-1:0]        i_waddr,
    input  logic [FTC_VEC_W-1:0] i_wdata,
    input  logic [AW-1:0]        i_raddr,
    output logic [FTC_VEC_W-1:0] o_rdata
);

    logic [FTC_VEC_W-1:0] r_mem [DEPTH];

    // NOTE: the array has no reset on purpose; loaded vectors must survive a reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (32'(i_raddr) < 32'(DEPTH)) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/ftc_vector_runner.sv
// Stimulus/check engine for the FTC adder cell: drives stored stimuli, samples the
// FTC result SETTLE cycles later and tallies mismatches against the stored expectations.
module ftc_vector_runner
    import ftc_pkg::*;
#(
    parameter int DEPTH  = 9,
    parameter int SETTLE = 0,
    parameter int ERR_W  = 7
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load_en,
    input  logic [$clog2(DEPTH)-1:0]     load_addr,
    input  logic [FTC_VEC_W-1:0]         load_data,
    input  logic [$clog2(DEPTH+1)-1:0]   num_vec,
    input  logic                         start,
    output logic [FTC_IN_W-1:0]          dut_in,
    input  logic [FTC_OUT_W-1:0]         dut_out,
    output logic                         busy,
    output logic                         done,
    output logic [ERR_W-1:0]             errors,
    output logic [ERR_W-1:0]             vec_idx,
    output logic                         fail_valid,
    output logic [ERR_W-1:0]             fail_index,
    output logic [FTC_OUT_W-1:0]         fail_got
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = $clog2(DEPTH + 1);
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;

    ftc_run_state_e         r_state;
    ftc_run_state_e         w_state_nxt;
    logic [AW-1:0]          r_idx;
    logic [NW-1:0]          r_num;
    logic [SW-1:0]          r_settle;
    logic [FTC_IN_W-1:0]    r_dut_in;
    logic [FTC_OUT_W-1:0]   r_exp;
    logic [ERR_W-1:0]       r_errors;
    logic                   r_fail_valid;
    logic [ERR_W-1:0]       r_fail_index;
    logic [FTC_OUT_W-1:0]   r_fail_got;

    logic                   w_we;
    logic                   w_accept;
    logic                   w_cmp;
    logic                   w_last;
    logic                   w_mismatch;
    logic [NW-1:0]          w_num_clamp;
    logic [AW-1:0]          w_rd_addr;
    logic [FTC_VEC_W-1:0]   w_mem_rd;
    logic [FTC_VEC_W-1:0]   w_rd_vec;

    assign w_we        = load_en && (r_state != RUN) && (32'(load_addr) < 32'(DEPTH));
    assign w_num_clamp = (32'(num_vec) > 32'(DEPTH)) ? NW'(DEPTH) : num_vec;
    assign w_last      = (NW'(r_idx) + NW'(1)) == r_num;
    assign w_mismatch  = dut_out != r_exp;

    // The store is read one slot ahead of the driven vector; a write landing on the
    // same edge as start is forwarded so the run sees the new data.
    assign w_rd_addr = w_accept ? '0 : r_idx + AW'(1);
    assign w_rd_vec  = (w_we && (load_addr == w_rd_addr)) ? load_data : w_mem_rd;

    ftc_vec_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_mem_rd)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every output of this block is defaulted first so no latch is inferred.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cmp       = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (w_num_clamp == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (r_settle == SW'(SETTLE)) begin
                    w_cmp = 1'b1;
                    if (w_last) begin
                        w_state_nxt = DONE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_num        <= '0;
            r_settle     <= '0;
            r_dut_in     <= '0;
            r_exp        <= '0;
            r_errors     <= '0;
            r_fail_valid <= 1'b0;
            r_fail_index <= '0;
            r_fail_got   <= '0;
        end else if (w_accept) begin
            r_errors     <= '0;
            r_fail_valid <= 1'b0;
            r_fail_index <= '0;
            r_fail_got   <= '0;
            r_num        <= w_num_clamp;
            r_settle     <= '0;
            r_idx        <= '0;
            if (w_num_clamp != '0) begin
                r_dut_in <= vec_stim(w_rd_vec);
                r_exp    <= vec_exp(w_rd_vec);
            end
        end else if (w_cmp) begin
            r_settle <= '0;
            if (w_mismatch) begin
                if (r_errors != '1) begin
                    r_errors <= r_errors + ERR_W'(1);
                end
                if (!r_fail_valid) begin
                    r_fail_valid <= 1'b1;
                    r_fail_index <= ERR_W'(r_idx);
                    r_fail_got   <= dut_out;
                end
            end
            if (!w_last) begin
                r_idx    <= r_idx + AW'(1);
                r_dut_in <= vec_stim(w_rd_vec);
                r_exp    <= vec_exp(w_rd_vec);
            end
        end else if (r_state == RUN) begin
            r_settle <= r_settle + SW'(1);
        end
    end

    assign dut_in     = r_dut_in;
    assign busy       = (r_state == RUN);
    assign done       = (r_state == DONE);
    assign errors     = r_errors;
    assign vec_idx    = ERR_W'(r_idx);
    assign fail_valid = r_fail_valid;
    assign fail_index = r_fail_index;
    assign fail_got   = r_fail_got;

endmodule

// File: doc/ftc_vector_runner.md
# ftc_vector_runner

Synthesizable stimulus/check engine for the five-to-three counter (FTC) adder cell. It holds a small vector store and steps through it when started. For each vector it drives the 5-bit stimulus onto the FTC inputs, samples the FTC's 3-bit result after a fixed settle time, and compares it with the stored expected value. It sits directly upstream of the FTC under test and replaces the file-driven simulation loop for on-chip and emulation runs.

## Interface
Parameters:
- `DEPTH`, 9, number of vector slots.
- `SETTLE`, 0, extra wait cycles between driving a vector and sampling its result.
- `ERR_W`, 7, width of the error counter and of `vec_idx`.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load_en`  in  1  write strobe for the vector store.
- `load_addr`  in  $clog2(DEPTH)  slot to write.
- `load_data`  in  8  vector: [7:3] stimulus {cin,i1,i2,i3,i4}; [2:0] expected {c,cout,s}.
- `num_vec`  in  $clog2(DEPTH+1)  vectors to run; sampled at start; values above DEPTH clamp to DEPTH.
- `start`  in  1  single-cycle run request.
- `dut_in`  out  5  registered stimulus {cin,i1,i2,i3,i4} to FTC.
- `dut_out`  in  3  FTC result {c,cout,s}.
- `busy`  out  1  run in progress.
- `done`  out  1  run finished; held until next accepted start.
- `errors`  out  ERR_W  mismatch count; saturates at all-ones.
- `vec_idx`  out  ERR_W  index of the vector currently driven.
- `fail_valid`  out  1  sticky; at least one mismatch this run.
- `fail_index`  out  ERR_W  index of the first failing vector.
- `fail_got`  out  3  `dut_out` captured at the first failure.

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- While `rst_n` is low, every output is 0: `dut_in`, `busy`, `done`, `errors`, `vec_idx`, `fail_*`. The vector store is not reset.
- Writes via `load_en` are accepted in IDLE and DONE and ignored in RUN. A write to an address ≥ DEPTH is ignored.
- `start` in IDLE or DONE:
  - clears `errors`, `fail_*` and `done`;
  - latches the clamped `num_vec` as N;
  - if N = 0, goes straight to DONE;
  - otherwise drives `dut_in` = stim[0], sets `vec_idx` = 0, and enters RUN.
- `start` in RUN is ignored.
- RUN:
  - A settle counter counts SETTLE cycles.
  - On the compare edge, `dut_out` is compared with exp[`vec_idx`].
  - On a mismatch, `errors` increments with saturation. If `fail_valid` was 0, the block also captures `fail_index` = `vec_idx`, `fail_got` = `dut_out`, and sets `fail_valid`.
  - On the same edge, if `vec_idx` < N−1, the next stimulus is driven and `vec_idx` increments. Otherwise the FSM enters DONE.
- In DONE, `dut_in` holds the last stimulus, and `errors` and `fail_*` hold their values.
- `busy` is 1 exactly in RUN. `done` is 1 exactly in DONE.
- `load_en` and `start` asserted together in DONE or IDLE: the write takes effect, and the run reads the new data.

## Timing
- Start is accepted at edge S. Vector k is driven from edge S + k·(SETTLE+1).
- Vector k is compared at edge S + (k+1)·(SETTLE+1).
- `done` rises after edge S + N·(SETTLE+1).
- With SETTLE = 0 and N = 9, `done` is high 9 cycles after the start edge.
- `dut_out` must be stable at the compare edge. The FTC is combinational, so SETTLE = 0 suffices for it.
- Vector store reads are combinational from an index register, which adds no latency.
- Reset asserted mid-run aborts at once to IDLE with all outputs 0. Stored vectors survive.

## Structure
- Package `ftc_pkg` holds:
  - `FTC_IN_W` = 5, `FTC_OUT_W` = 3, `FTC_VEC_W` = 8;
  - the state enum `ftc_run_state_e` (IDLE/RUN/DONE);
  - functions `vec_stim()` and `vec_exp()` that slice a vector.
- One sub-module, `ftc_vec_mem`: DEPTH×8 register array with a synchronous write port and an asynchronous read port.
- FSM, counters and compare logic live in `ftc_vector_runner`.

## Test plan
- Load 9 correct vectors for a reference FTC model, N = 9, start → `errors` = 0, `fail_valid` = 0, `done` at S+9, `vec_idx` sweeps 0..8.
- Same vectors with the model's `s` forced wrong only for stimulus 5'b10110, stored at slot 4 → `errors` = 1, `fail_index` = 4, `fail_got` = that wrong value.
- N = 0, start → `done` on the next cycle, `busy` never high, `errors` = 0.
- SETTLE = 2, N = 3 → vector k is driven at S+3k and compared at S+3(k+1); `done` after S+9.
- Reset mid-run at vector 5 → all outputs 0 in the reset cycle. Restart with N = 9 → clean pass; vectors retained.
- ERR_W = 2, 9 all-failing vectors → `errors` saturates at 3, `fail_index` = 0. `start` pulsed during RUN → ignored. `load_en` during RUN → store unchanged.
